// File: rtl/cam_pingpong_buf_if.sv
// Bundle of capture-side and reader-side signals for the ping-pong frame store.
//
// Handshake semantics: cap_valid qualifies cap_data for exactly one cycle and
// there is no back-pressure (the camera cannot be stalled). cap_sof/cap_eof are
// single-cycle pulses. On the read side a cycle with rd_en high is a request;
// its answer appears one cycle later, qualified by rd_valid. rd_release is a
// single-cycle pulse that hands the ready frame back to the capture side.
interface cam_pingpong_buf_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 7
);
  logic              cap_sof;
  logic              cap_eof;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_release;
  logic              frame_ready;
  logic [ADDR_W:0]   frame_len;
  logic [7:0]        drop_cnt;
  logic              overflow;
  logic [1:0]        cap_state;   // debug view of the capture FSM

  modport master (
    output cap_sof, cap_eof, cap_valid, cap_data, rd_en, rd_addr, rd_release,
    input  rd_data, rd_valid, frame_ready, frame_len, drop_cnt, overflow, cap_state
  );

  modport slave (
    input  cap_sof, cap_eof, cap_valid, cap_data, rd_en, rd_addr, rd_release,
    output rd_data, rd_valid, frame_ready, frame_len, drop_cnt, overflow, cap_state
  );
endinterface

// File: rtl/cam_pingpong_buf.sv
// Double-buffered camera frame store. Two banks cycle through
// FREE -> FILL -> FULL -> READ -> FREE so the capture path never writes into
// a frame the reader still owns. Frames arriving with no free bank are dropped
// and counted; pixels beyond DEPTH are discarded and flagged.
module cam_pingpong_buf #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 120,
  parameter int ADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  cam_pingpong_buf_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP} cap_state_t;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_READ} bank_state_t;

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  cap_state_t        state;
  cap_state_t        state_nxt;
  bank_state_t       bank_st  [2];
  logic [ADDR_W:0]   bank_len [2];
  logic [ADDR_W:0]   ptr;
  logic              cur_bank;
  logic [7:0]        drop_cnt;
  logic              overflow;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] mem [2][DEPTH];

  // Decisions that depend only on bank status from before the current edge.
  logic any_free, sel_bank, sof_ok, sof_drop;
  logic read_busy, rd_bank, promote, promo_bank, release_ok;

  assign any_free   = (bank_st[0] == B_FREE) || (bank_st[1] == B_FREE);
  assign sel_bank   = (bank_st[0] == B_FREE) ? 1'b0 : 1'b1;
  assign sof_ok     = bus.cap_sof && any_free;
  assign sof_drop   = bus.cap_sof && !any_free;
  assign read_busy  = (bank_st[0] == B_READ) || (bank_st[1] == B_READ);
  assign rd_bank    = (bank_st[1] == B_READ);
  assign promote    = !read_busy && ((bank_st[0] == B_FULL) || (bank_st[1] == B_FULL));
  assign promo_bank = (bank_st[0] == B_FULL) ? 1'b0 : 1'b1;
  assign release_ok = bus.rd_release && read_busy;

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Capture FSM next state: sof always restarts (or drops), eof ends a capture.
  always_comb begin
    state_nxt = state;
    if (bus.cap_sof)                            state_nxt = sof_ok ? S_CAPTURE : S_DROP;
    else if (state == S_CAPTURE && bus.cap_eof) state_nxt = S_IDLE;
  end

  // Capture FSM outputs: where a pixel lands, frame close, overflow events.
  // A pixel that comes with an accepted sof belongs to the new frame.
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              px_cur;
  logic              px_ovf;
  logic              close;
  logic [ADDR_W:0]   close_len;
  always_comb begin
    wr_en     = 1'b0;
    wr_bank   = cur_bank;
    wr_addr   = ptr[ADDR_W-1:0];
    px_cur    = 1'b0;
    px_ovf    = 1'b0;
    close     = 1'b0;
    close_len = ptr;
    if (state == S_CAPTURE) begin
      close = bus.cap_eof;
      if (bus.cap_valid && !bus.cap_sof) begin
        if (ptr < DEPTH_P) px_cur = 1'b1;
        else               px_ovf = 1'b1;
      end
    end
    if (px_cur) begin
      wr_en     = 1'b1;
      close_len = ptr + 1'b1;
    end
    if (sof_ok && bus.cap_valid) begin
      wr_en   = 1'b1;
      wr_bank = sel_bank;
      wr_addr = '0;
    end
  end

  // Write pointer and active bank tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      cur_bank <= 1'b0;
    end else if (sof_ok) begin
      ptr      <= bus.cap_valid ? (ADDR_W+1)'(1) : '0;
      cur_bank <= sel_bank;
    end else if (px_cur) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Bank ownership: each transition is keyed on the bank's pre-edge status,
  // so a bank closed this edge cannot also be claimed or promoted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bank_st[i]  <= B_FREE;
        bank_len[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (bank_st[i])
          B_FREE: if (sof_ok && sel_bank == 1'(i)) bank_st[i] <= B_FILL;
          B_FILL: begin
            if (close) begin
              bank_st[i]  <= B_FULL;
              bank_len[i] <= close_len;
            end else if (bus.cap_sof) begin
              bank_st[i] <= B_FREE;
            end
          end
          B_FULL: if (promote && promo_bank == 1'(i)) bank_st[i] <= B_READ;
          B_READ: if (release_ok) bank_st[i] <= B_FREE;
          default: bank_st[i] <= B_FREE;
        endcase
      end
    end
  end

  // Dropped-frame counter (saturating) and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (sof_drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (px_ovf) overflow <= 1'b1;
    end
  end

  // Pixel storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= bus.cap_data;
  end

  // Read port with one-cycle latency; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (bus.rd_en && read_busy) begin
      rd_valid <= 1'b1;
      rd_data  <= ({1'b0, bus.rd_addr} < DEPTH_P) ? mem[rd_bank][bus.rd_addr] : '0;
    end else if (bus.rd_en) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.frame_ready = read_busy;
  assign bus.frame_len   = read_busy ? bank_len[rd_bank] : '0;
  assign bus.drop_cnt    = drop_cnt;
  assign bus.overflow    = overflow;
  assign bus.cap_state   = state;

endmodule

// File: doc/cam_pingpong_buf.md
Name: cam_pingpong_buf

Overview:
- Parametrised double-buffered pixel frame store between the camera capture path and the Wishbone-side reader in wb_camera.
- Successor to the single-bank camera RAM. Adds configurable width and depth, and two banks with ownership handoff, so capture never overwrites a frame being read.
- Per-bank status tracking, frame-length reporting, dropped-frame counting and overflow flagging.
- Single clock domain; the capture interface is synchronised to clk upstream.

Parameters:
- DATA_W, 4, pixel width in bits.
- DEPTH, 120, maximum pixels per frame (per bank).
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_sof  in  1  start-of-frame pulse.
- cap_eof  in  1  end-of-frame pulse.
- cap_valid  in  1  cap_data valid this cycle.
- cap_data  in  DATA_W  pixel.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address within the ready frame.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid.
- rd_release  in  1  reader finished with the current frame.
- frame_ready  out  1  a complete frame is owned by the reader.
- frame_len  out  ADDR_W+1  pixel count of the ready frame.
- drop_cnt  out  8  frames dropped for lack of a free bank; saturates at 255.
- overflow  out  1  sticky: pixels discarded because a frame exceeded DEPTH.

Behaviour:
- Reset: every output is 0. Both banks FREE. Capture FSM in IDLE. Write pointer 0. Memory contents are not cleared. Reset mid-frame abandons the frame; no partial frame is ever presented.
- Bank status: each bank is one of FREE, FILL, FULL, READ. Each bank has a stored length register.
- Capture FSM states: IDLE, CAPTURE, DROP.
- cap_sof, any capture state: if a bank is FREE, it is selected (lowest index on tie). The previous FILL bank, if any, returns to FREE. The selected bank goes to FILL, the pointer resets to 0, and the FSM goes to CAPTURE.
- cap_sof with no FREE bank: drop_cnt increments (saturating at 255) and the FSM goes to DROP. Any FILL bank returns to FREE.
- A cap_valid in the same cycle as an accepted cap_sof writes address 0.
- CAPTURE:
  - cap_valid with pointer < DEPTH: write cap_data at the pointer, then pointer+1.
  - cap_valid with pointer = DEPTH: pixel discarded, overflow set to 1 (cleared only by rst).
- cap_eof in CAPTURE: bank goes FILL->FULL, length = pointer plus 1 if a pixel is accepted in the same cycle. FSM goes to IDLE.
- A zero-length frame (eof with no pixels) is still marked FULL with length 0.
- cap_eof in IDLE or DROP: ignored. Pixels in IDLE or DROP: ignored.
- Same-cycle cap_eof and cap_sof: eof closes the current frame first. sof then evaluates bank status from before this edge, so the bank just closed is not free.
- Promotion: at an edge where no bank is READ and a bank is FULL (lowest index on tie), that bank becomes READ. frame_ready=1 and frame_len=stored length, both from the next cycle.
- rd_release while frame_ready=1: the READ bank goes to FREE and frame_ready=0 the next cycle. Promotion of another FULL bank happens no earlier than the edge after that, so there is at least one cycle with frame_ready=0 between frames.
- rd_release while frame_ready=0: ignored.
- Read port, 1-cycle latency:
  - rd_en with frame_ready=1 and rd_addr < DEPTH: rd_data = READ bank[rd_addr] and rd_valid=1 on the next cycle.
  - rd_addr >= DEPTH: rd_data=0, rd_valid=1.
  - rd_en with frame_ready=0: rd_data=0, rd_valid=0.
  - Otherwise rd_valid=0 and rd_data holds its last value.
- A read in the same cycle as rd_release is served from the bank being released.
- A write never targets a READ or FULL bank.

Test Plan:
- Basic frame: sof, 5 pixels 1,2,3,4,5, eof -> frame_ready=1 two cycles after eof, frame_len=5. rd_en on addr 0..4 -> rd_data 1..5, each one cycle after its request, rd_valid=1.
- Ping-pong: while frame A (len 3) is READ, capture frame B (len 4, pixels 9). rd_release -> frame_ready drops for exactly one cycle, then rises with frame_len=4 and data 9,9,9,9. Frame A contents are never corrupted during B's capture.
- Drop: bank0 READ and bank1 FULL, new sof -> drop_cnt=1, following pixels ignored, bank1 data unchanged. Repeat 300 drops -> drop_cnt=255.
- Overflow: DEPTH=120, write 125 pixels then eof -> overflow=1, frame_len=120, addr 119 holds pixel 120.
- Same-cycle eof+sof with one bank READ: frame closes as FULL, new frame dropped, drop_cnt+1. Same-cycle eof+sof with both other banks FREE: next frame captures into the other bank.
- Reset mid-capture after 3 pixels -> all outputs 0, frame_ready stays 0, next full frame captures normally into bank0.
